// File: rtl/output_pooling_pkg.sv
// -----------------------------------------------------------------------------
// output_pooling_pkg
// Shared definitions for the output pooling memory reader and writer-side
// decoder: default width constants and the reader FSM state encoding.
// -----------------------------------------------------------------------------
package output_pooling_pkg;

  localparam int DEF_CHANNEL_WIDTH = 7;
  localparam int DEF_ROW_WIDTH     = 2;
  localparam int DEF_COL_WIDTH     = 2;
  localparam int DEF_BRAM_NUM      = 4;
  localparam int DEF_BRAM_DEPTH    = 1152;
  localparam int DEF_DATA_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

endpackage

// File: rtl/output_pooling_skid_fifo.sv
// -----------------------------------------------------------------------------
// output_pooling_skid_fifo
// Two-entry FIFO holding BRAM read data plus its sideband (mask, channel,
// row, col, last). Simultaneous push and pop are allowed; a push into a
// full FIFO without a matching pop is dropped (the reader's credit logic
// never does that).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, clears storage and pointers
//   push       write push_data this cycle
//   push_data  entry to store
//   pop        consume the head entry (ignored when empty)
//   out_valid  head entry present
//   out_data   head entry, held until popped
//   count      current occupancy, 0..2
// -----------------------------------------------------------------------------
module output_pooling_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem0_q;
  logic [WIDTH-1:0] mem1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_q <= push_data;
        else          mem0_q <= push_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = rd_ptr_q ? mem1_q : mem0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/output_pooling_mem_reader.sv
// -----------------------------------------------------------------------------
// output_pooling_mem_reader
// Reads a pooled output map back out of OUTPUT_BRAM_NUM parallel BRAM lanes
// in the layout produced by the pooling writer and streams it as beats with
// valid/ready handshake. One beat = one address = up to OUTPUT_BRAM_NUM
// consecutive channels at one (row, col).
//
//   address = G*P*P + row*P + col,  G = (channel - start) / OUTPUT_BRAM_NUM
//
// Build option:
//   OUTPUT_POOLING_READER_LANE_ZERO_EN  when defined, lanes whose mask bit is
//                                       clear are forced to zero in o_data;
//                                       otherwise raw BRAM data passes through.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start                       start pulse, sampled only in IDLE
//   i_output_pooling_size         pooled map side P
//   i_output_start_index_channel  first channel
//   i_output_end_index_channel    last channel (inclusive)
//   o_bram_rd_en, o_bram_addr     read strobe and common address to all lanes
//   i_bram_rdata                  lane data, valid one cycle after rd_en
//   o_valid, i_ready              beat handshake
//   o_data, o_lane_mask           beat data and active lanes
//   o_channel, o_row, o_col       base channel and pooled position of beat
//   o_last                        final beat of the frame
//   o_busy, o_done                high outside IDLE, one-cycle completion pulse
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | waiting for i_start; config latched on accept
//   ST_ISSUE | issuing addresses 0..total-1 as buffer credit allows
//   ST_DRAIN | all reads issued, waiting for the last beat to be accepted
//   ST_DONE  | one cycle, o_done high
// -----------------------------------------------------------------------------
module output_pooling_mem_reader
  import output_pooling_pkg::*;
#(
  parameter int OUTPUT_CHANNEL_WIDTH      = DEF_CHANNEL_WIDTH,
  parameter int OUTPUT_ROW_WIDTH          = DEF_ROW_WIDTH,
  parameter int OUTPUT_COL_WIDTH          = DEF_COL_WIDTH,
  parameter int OUTPUT_BRAM_NUM           = DEF_BRAM_NUM,
  parameter int OUTPUT_BRAM_DEPTH         = DEF_BRAM_DEPTH,
  parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
  parameter int DATA_WIDTH                = DEF_DATA_WIDTH
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_start,
  input  logic [OUTPUT_COL_WIDTH-1:0]             i_output_pooling_size,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]         i_output_start_index_channel,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0]         i_output_end_index_channel,
  output logic                                    o_bram_rd_en,
  output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0]    o_bram_addr,
  input  logic [OUTPUT_BRAM_NUM*DATA_WIDTH-1:0]   i_bram_rdata,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic [OUTPUT_BRAM_NUM*DATA_WIDTH-1:0]   o_data,
  output logic [OUTPUT_BRAM_NUM-1:0]              o_lane_mask,
  output logic [OUTPUT_CHANNEL_WIDTH-1:0]         o_channel,
  output logic [OUTPUT_ROW_WIDTH-1:0]             o_row,
  output logic [OUTPUT_COL_WIDTH-1:0]             o_col,
  output logic                                    o_last,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int CW     = OUTPUT_CHANNEL_WIDTH;
  localparam int RW     = OUTPUT_ROW_WIDTH;
  localparam int PW     = OUTPUT_COL_WIDTH;
  localparam int NUM    = OUTPUT_BRAM_NUM;
  localparam int AW     = OUTPUT_BRAM_ADDRESS_WIDTH;
  localparam int DW     = DATA_WIDTH;
  // channel count needs CW+1 bits; one more keeps the ceil() add from wrapping
  localparam int GW     = CW + 2;
  localparam int RC_W   = (RW > PW) ? RW : PW;
  localparam int SIDE_W = NUM + CW + RW + PW + 1;
  localparam int LANE_W = NUM * DW;
  localparam int FIFO_W = LANE_W + SIDE_W;

  pool_state_t       state_q;
  logic [PW-1:0]     p_q;
  logic [GW-1:0]     groups_q;
  logic [GW-1:0]     grp_q;
  logic [NUM-1:0]    last_mask_q;
  logic [RW-1:0]     row_q;
  logic [PW-1:0]     col_q;
  logic [CW-1:0]     base_q;
  logic [AW-1:0]     addr_q;
  logic              pend_q;
  logic [SIDE_W-1:0] pend_side_q;

  // ---------------------------------------------------------------------------
  // Frame geometry, decoded from the live inputs and latched on i_start
  // ---------------------------------------------------------------------------
  logic [GW-1:0]  n_c;
  logic [GW-1:0]  groups_c;
  logic [GW-1:0]  rem_c;
  logic [NUM-1:0] last_mask_c;
  logic           empty_c;

  always_comb begin
    n_c         = GW'(i_output_end_index_channel) - GW'(i_output_start_index_channel) + GW'(1);
    groups_c    = (n_c + GW'(NUM - 1)) / GW'(NUM);
    rem_c       = n_c % GW'(NUM);
    last_mask_c = '0;
    for (int k = 0; k < NUM; k++) begin
      last_mask_c[k] = (rem_c == '0) || (GW'(k) < rem_c);
    end
    empty_c = (i_output_pooling_size == '0) ||
              (i_output_end_index_channel < i_output_start_index_channel);
  end

  // ---------------------------------------------------------------------------
  // Position of the address being issued this cycle
  // ---------------------------------------------------------------------------
  logic              last_grp_c;
  logic              row_end_c;
  logic              col_end_c;
  logic              last_addr_c;
  logic [NUM-1:0]    mask_c;
  logic [SIDE_W-1:0] side_c;

  always_comb begin
    last_grp_c  = (grp_q == groups_q - GW'(1));
    row_end_c   = (RC_W'(row_q) == RC_W'(p_q) - RC_W'(1));
    col_end_c   = (col_q == p_q - PW'(1));
    last_addr_c = last_grp_c && row_end_c && col_end_c;
    mask_c      = last_grp_c ? last_mask_q : '1;
    side_c      = {mask_c, base_q, row_q, col_q, last_addr_c};
  end

  // ---------------------------------------------------------------------------
  // Read credit. The count is taken after this cycle's accepted beat so a
  // full-rate stream keeps one read issuing per cycle; occupancy next cycle
  // equals this count, so the 2-entry buffer cannot overflow.
  // ---------------------------------------------------------------------------
  logic             fifo_valid;
  logic [1:0]       fifo_count;
  logic [FIFO_W-1:0] fifo_out;
  logic             pop;
  logic [2:0]       committed;

  assign pop          = fifo_valid && i_ready;
  assign committed    = 3'(fifo_count) + 3'(pend_q) - 3'(pop);
  assign o_bram_rd_en = (state_q == ST_ISSUE) && (committed < 3'd2);
  assign o_bram_addr  = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      groups_q    <= '0;
      grp_q       <= '0;
      last_mask_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_side_q <= '0;
    end else begin
      pend_q <= o_bram_rd_en;
      if (o_bram_rd_en) pend_side_q <= side_c;

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            p_q         <= i_output_pooling_size;
            groups_q    <= groups_c;
            last_mask_q <= last_mask_c;
            base_q      <= i_output_start_index_channel;
            grp_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            state_q     <= empty_c ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (o_bram_rd_en) begin
            addr_q <= addr_q + AW'(1);
            if (col_end_c) begin
              col_q <= '0;
              if (row_end_c) begin
                row_q  <= '0;
                grp_q  <= grp_q + GW'(1);
                base_q <= base_q + CW'(NUM);
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + PW'(1);
            end
            if (last_addr_c) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && o_last) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data captured one cycle after the read, together with its sideband
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] push_lanes;

`ifdef OUTPUT_POOLING_READER_LANE_ZERO_EN
  logic [NUM-1:0] pend_mask;
  assign pend_mask = pend_side_q[SIDE_W-1 -: NUM];

  always_comb begin
    push_lanes = i_bram_rdata;
    for (int k = 0; k < NUM; k++) begin
      if (!pend_mask[k]) push_lanes[k*DW +: DW] = '0;
    end
  end
`else
  assign push_lanes = i_bram_rdata;
`endif

  output_pooling_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (pend_q),
    .push_data ({push_lanes, pend_side_q}),
    .pop       (pop),
    .out_valid (fifo_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign o_valid = fifo_valid;
  assign o_data  = fifo_out[SIDE_W +: LANE_W];
  assign {o_lane_mask, o_channel, o_row, o_col, o_last} = fifo_out[SIDE_W-1:0];
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);

endmodule
